// File: rtl/ex_mem_access_stage.sv
// Memory-access stage: owns the data memory and serialises loads/stores with a
// fixed multi-cycle latency. Optional MEM_STATS_EN adds load/store counters.
module ex_mem_access_stage #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] label_value,
  input  logic       label_flag,
  input  logic       write_mem_flag,
  input  logic       read_mem_flag,
  input  logic [7:0] alu_result,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg_b,
  output logic       stall,
  output logic       wb_valid,
  output logic       wb_reg_write,
  output logic [7:0] wb_data,
  output logic [7:0] wb_reg_a,
  output logic [7:0] wb_label_value,
  output logic       wb_label_flag,
  output logic       conflict_err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] load_count,
  output logic [15:0] store_count
`endif
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          is_store_q, is_store_d;
  logic          both_q, both_d;
  logic [7:0]    reg_a_q, reg_a_d;
  logic [7:0]    lv_q, lv_d;
  logic          lf_q, lf_d;

  logic          wb_valid_q, wb_valid_d;
  logic          wb_rw_q, wb_rw_d;
  logic [7:0]    wb_data_q, wb_data_d;
  logic [7:0]    wb_ra_q, wb_ra_d;
  logic [7:0]    wb_lv_q, wb_lv_d;
  logic          wb_lf_q, wb_lf_d;
  logic          ce_q, ce_d;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic          mem_op;

  assign mem_op = in_valid & (read_mem_flag | write_mem_flag);

  if (AW < 8) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^alu_result[7:AW];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_store_d = is_store_q;
    both_d     = both_q;
    reg_a_d    = reg_a_q;
    lv_d       = lv_q;
    lf_d       = lf_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    wb_ra_d    = wb_ra_q;
    wb_lv_d    = wb_lv_q;
    wb_lf_d    = wb_lf_q;
    ce_d       = 1'b0;
    mem_we     = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          addr_d     = alu_result[AW-1:0];
          data_d     = reg_b;
          is_store_d = write_mem_flag;
          both_d     = write_mem_flag & read_mem_flag;
          reg_a_d    = reg_a;
          lv_d       = label_value;
          lf_d       = label_flag;
          cnt_d      = LAT_M1;
          state_d    = BUSY;
        end else if (in_valid) begin
          wb_valid_d = 1'b1;
          wb_rw_d    = 1'b1;
          wb_data_d  = alu_result;
          wb_ra_d    = reg_a;
          wb_lv_d    = label_value;
          wb_lf_d    = label_flag;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Upstream still holds this op; it advances on this edge, inputs ignored.
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_ra_d    = reg_a_q;
          wb_lv_d    = lv_q;
          wb_lf_d    = lf_q;
          if (is_store_q) begin
            mem_we    = 1'b1;
            wb_rw_d   = 1'b0;
            wb_data_d = '0;
            ce_d      = both_q;
          end else begin
            wb_rw_d   = 1'b1;
            wb_data_d = mem_q[addr_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      is_store_q <= 1'b0;
      both_q     <= 1'b0;
      reg_a_q    <= '0;
      lv_q       <= '0;
      lf_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_ra_q    <= '0;
      wb_lv_q    <= '0;
      wb_lf_q    <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_store_q <= is_store_d;
      both_q     <= both_d;
      reg_a_q    <= reg_a_d;
      lv_q       <= lv_d;
      lf_q       <= lf_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
      wb_ra_q    <= wb_ra_d;
      wb_lv_q    <= wb_lv_d;
      wb_lf_q    <= wb_lf_d;
      ce_q       <= ce_d;
    end
  end

  // Memory contents survive reset; a store pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_rw_q;
  assign wb_data        = wb_data_q;
  assign wb_reg_a       = wb_ra_q;
  assign wb_label_value = wb_lv_q;
  assign wb_label_flag  = wb_lf_q;
  assign conflict_err   = ce_q;

`ifdef MEM_STATS_EN
  logic        done_load;
  logic [15:0] load_cnt_q, store_cnt_q;

  assign done_load = (state_q == BUSY) && (cnt_q == '0) && !is_store_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (done_load && (load_cnt_q != '1)) begin
        load_cnt_q <= load_cnt_q + 16'd1;
      end
      if (mem_we && (store_cnt_q != '1)) begin
        store_cnt_q <= store_cnt_q + 16'd1;
      end
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_access_stage.sv
// Bench for ex_mem_access_stage: two instances (DEPTH 256 and 16) share stimulus
// and are checked against an array-based reference of the memory stage.
module tb_ex_mem_access_stage;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] label_value = '0;
  logic       label_flag = 1'b0;
  logic       write_mem_flag = 1'b0;
  logic       read_mem_flag = 1'b0;
  logic [7:0] alu_result = '0;
  logic [7:0] reg_a = '0;
  logic [7:0] reg_b = '0;

  logic       stall_a, wb_valid_a, wb_reg_write_a, wb_label_flag_a, conflict_err_a;
  logic [7:0] wb_data_a, wb_reg_a_a, wb_label_value_a;
  logic       stall_b, wb_valid_b, wb_reg_write_b, wb_label_flag_b, conflict_err_b;
  logic [7:0] wb_data_b, wb_reg_a_b, wb_label_value_b;
`ifdef MEM_STATS_EN
  logic [15:0] load_count_a, store_count_a, load_count_b, store_count_b;
`endif

  ex_mem_access_stage #(.DEPTH(256), .MEM_LATENCY(LAT)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .label_value(label_value),
    .label_flag(label_flag), .write_mem_flag(write_mem_flag), .read_mem_flag(read_mem_flag),
    .alu_result(alu_result), .reg_a(reg_a), .reg_b(reg_b), .stall(stall_a),
    .wb_valid(wb_valid_a), .wb_reg_write(wb_reg_write_a), .wb_data(wb_data_a),
    .wb_reg_a(wb_reg_a_a), .wb_label_value(wb_label_value_a), .wb_label_flag(wb_label_flag_a),
    .conflict_err(conflict_err_a)
`ifdef MEM_STATS_EN
    , .load_count(load_count_a), .store_count(store_count_a)
`endif
  );

  ex_mem_access_stage #(.DEPTH(16), .MEM_LATENCY(LAT)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .label_value(label_value),
    .label_flag(label_flag), .write_mem_flag(write_mem_flag), .read_mem_flag(read_mem_flag),
    .alu_result(alu_result), .reg_a(reg_a), .reg_b(reg_b), .stall(stall_b),
    .wb_valid(wb_valid_b), .wb_reg_write(wb_reg_write_b), .wb_data(wb_data_b),
    .wb_reg_a(wb_reg_a_b), .wb_label_value(wb_label_value_b), .wb_label_flag(wb_label_flag_b),
    .conflict_err(conflict_err_b)
`ifdef MEM_STATS_EN
    , .load_count(load_count_b), .store_count(store_count_b)
`endif
  );

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [7:0] d;
    logic [7:0] ra;
    logic [7:0] lv;
    logic       lf;
    logic       ce;
  } wb_t;

  wb_t obs_a, obs_b;
  assign obs_a = {wb_valid_a, wb_reg_write_a, wb_data_a, wb_reg_a_a, wb_label_value_a,
                  wb_label_flag_a, conflict_err_a};
  assign obs_b = {wb_valid_b, wb_reg_write_b, wb_data_b, wb_reg_a_b, wb_label_value_b,
                  wb_label_flag_b, conflict_err_b};

  logic [7:0] ref_a [256];
  logic [7:0] ref_b [16];
  int ld_cnt = 0;
  int st_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference: what one instruction should retire with, and how long it stalls.
  task automatic model(input logic rd, input logic wr, input logic [7:0] alu,
                       input logic [7:0] rb, input logic [7:0] ra, input logic [7:0] lv,
                       input logic lf, output wb_t ea, output wb_t eb, output int est);
    ea = '0;
    ea.v = 1'b1; ea.ra = ra; ea.lv = lv; ea.lf = lf;
    est = (rd || wr) ? LAT : 0;
    if (wr) begin
      ref_a[alu] = rb;
      ref_b[alu[3:0]] = rb;
      ea.rw = 1'b0; ea.d = 8'h00; ea.ce = rd;
      eb = ea;
      if (st_cnt < 65535) st_cnt++;
    end else if (rd) begin
      ea.rw = 1'b1;
      eb = ea;
      ea.d = ref_a[alu];
      eb.d = ref_b[alu[3:0]];
      if (ld_cnt < 65535) ld_cnt++;
    end else begin
      ea.rw = 1'b1; ea.d = alu;
      eb = ea;
    end
  endtask

  // Upstream register emulation: present one op, hold while stalled, then idle.
  task automatic issue(input logic rd, input logic wr, input logic [7:0] alu,
                       input logic [7:0] rb, input logic [7:0] ra, input logic [7:0] lv,
                       input logic lf, output wb_t ga, output wb_t gb,
                       output int nsa, output int nsb, output int early);
    @(posedge clk); #1;
    in_valid = 1'b1; read_mem_flag = rd; write_mem_flag = wr; alu_result = alu;
    reg_b = rb; reg_a = ra; label_value = lv; label_flag = lf;
    nsa = 0; nsb = 0; early = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_a) nsa++;
      if (stall_b) nsb++;
      if (wb_valid_a || wb_valid_b) early++;
      if (!stall_a && !stall_b) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; read_mem_flag = 1'b0; write_mem_flag = 1'b0;
    @(negedge clk);
    ga = obs_a; gb = obs_b;
  endtask

  task automatic test_reset();
    wb_t ga, gb, ea, eb;
    int nsa, nsb, early, est;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (obs_a !== '0 || stall_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_a wb=%h stall=%b required wb=0 stall=0", obs_a, stall_a); end
    n_checks++; if (obs_b !== '0 || stall_b !== 1'b0) begin n_fail++;
      $display("FAIL reset_b wb=%h stall=%b required wb=0 stall=0", obs_b, stall_b); end
    // Fill memory so every later load has a known expected value.
    for (int i = 0; i < 256; i++) begin
      model(1'b0, 1'b1, 8'(i), 8'(i) ^ 8'hC3, 8'h00, 8'h00, 1'b0, ea, eb, est);
      issue(1'b0, 1'b1, 8'(i), 8'(i) ^ 8'hC3, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    end
    model(1'b0, 1'b1, 8'h05, 8'h00, 8'h11, 8'h22, 1'b0, ea, eb, est);
    issue(1'b0, 1'b1, 8'h05, 8'h00, 8'h11, 8'h22, 1'b0, ga, gb, nsa, nsb, early);
    // Store 0x33 to 0x05, abandoned by a 2-cycle reset while busy.
    @(posedge clk); #1;
    in_valid = 1'b1; write_mem_flag = 1'b1; alu_result = 8'h05; reg_b = 8'h33;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; write_mem_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ld_cnt = 0; st_cnt = 0;
    @(negedge clk);
    n_checks++; if (obs_a !== '0 || stall_a !== 1'b0) begin n_fail++;
      $display("FAIL midbusy_reset_a wb=%h stall=%b required wb=0 stall=0", obs_a, stall_a); end
    n_checks++; if (obs_b !== '0 || stall_b !== 1'b0) begin n_fail++;
      $display("FAIL midbusy_reset_b wb=%h stall=%b required wb=0 stall=0", obs_b, stall_b); end
`ifdef MEM_STATS_EN
    n_checks++; if (load_count_a !== 16'd0 || store_count_a !== 16'd0) begin n_fail++;
      $display("FAIL reset_stats ld=%0d st=%0d required 0 0", load_count_a, store_count_a); end
`endif
    model(1'b1, 1'b0, 8'h05, 8'h00, 8'h44, 8'h55, 1'b1, ea, eb, est);
    issue(1'b1, 1'b0, 8'h05, 8'h00, 8'h44, 8'h55, 1'b1, ga, gb, nsa, nsb, early);
    n_checks++; if (ga !== ea || ga.d !== 8'h00) begin n_fail++;
      $display("FAIL abandoned_store_a got=%h required=%h", ga, ea); end
    n_checks++; if (gb !== eb) begin n_fail++;
      $display("FAIL abandoned_store_b got=%h required=%h", gb, eb); end
  endtask

  task automatic test_store_load();
    wb_t ga, gb, ea, eb;
    int nsa, nsb, early, est;
    model(1'b0, 1'b1, 8'h10, 8'hA5, 8'h01, 8'h02, 1'b0, ea, eb, est);
    issue(1'b0, 1'b1, 8'h10, 8'hA5, 8'h01, 8'h02, 1'b0, ga, gb, nsa, nsb, early);
    n_checks++; if (nsa !== LAT || nsb !== LAT || early !== 0) begin n_fail++;
      $display("FAIL store_stall stall_a=%0d stall_b=%0d early_wb=%0d required %0d %0d 0",
               nsa, nsb, early, LAT, LAT); end
    n_checks++; if (ga !== ea || ga.rw !== 1'b0) begin n_fail++;
      $display("FAIL store_wb got=%h required=%h", ga, ea); end
    model(1'b1, 1'b0, 8'h10, 8'h00, 8'h03, 8'h04, 1'b0, ea, eb, est);
    issue(1'b1, 1'b0, 8'h10, 8'h00, 8'h03, 8'h04, 1'b0, ga, gb, nsa, nsb, early);
    n_checks++; if (nsa !== LAT || early !== 0) begin n_fail++;
      $display("FAIL load_stall stall=%0d early_wb=%0d required %0d 0", nsa, early, LAT); end
    n_checks++; if (ga !== ea || ga.d !== 8'hA5 || gb !== eb) begin n_fail++;
      $display("FAIL load_after_store got=%h/%h required=%h/%h", ga, gb, ea, eb); end
  endtask

  task automatic test_back_to_back();
    wb_t ea [3];
    wb_t eb [3];
    wb_t hold;
    int est;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        in_valid = 1'b1; read_mem_flag = 1'b0; write_mem_flag = 1'b0;
        alu_result = 8'(k + 1); reg_a = 8'(8'h90 + k); label_value = 8'h40; label_flag = 1'b1;
        model(1'b0, 1'b0, alu_result, reg_b, reg_a, 8'h40, 1'b1, ea[k], eb[k], est);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++; if (stall_a !== 1'b0) begin n_fail++;
        $display("FAIL b2b_stall cycle=%0d stall=%b required 0", k, stall_a); end
      if (k > 0) begin
        n_checks++; if (obs_a !== ea[k-1] || obs_b !== eb[k-1]) begin n_fail++;
          $display("FAIL b2b_wb cycle=%0d got=%h required=%h", k, obs_a, ea[k-1]); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    hold = ea[2]; hold.v = 1'b0;
    n_checks++; if (obs_a !== hold) begin n_fail++;
      $display("FAIL b2b_hold got=%h required=%h", obs_a, hold); end
  endtask

  task automatic test_wrap();
    wb_t ga, gb, ea, eb;
    int nsa, nsb, early, est;
    model(1'b0, 1'b1, 8'h03, 8'h11, 8'h00, 8'h00, 1'b0, ea, eb, est);
    issue(1'b0, 1'b1, 8'h03, 8'h11, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    model(1'b0, 1'b1, 8'h23, 8'h7E, 8'h00, 8'h00, 1'b0, ea, eb, est);
    issue(1'b0, 1'b1, 8'h23, 8'h7E, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    model(1'b1, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, ea, eb, est);
    issue(1'b1, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    n_checks++; if (gb !== eb || gb.d !== 8'h7E) begin n_fail++;
      $display("FAIL wrap_depth16 got=%h required=%h", gb, eb); end
    n_checks++; if (ga !== ea || ga.d !== 8'h11) begin n_fail++;
      $display("FAIL nowrap_depth256 got=%h required=%h", ga, ea); end
  endtask

  task automatic test_conflict();
    wb_t ga, gb, ea, eb;
    int nsa, nsb, early, est;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ld_cnt = 0; st_cnt = 0;
    model(1'b1, 1'b1, 8'h08, 8'h5A, 8'h00, 8'h00, 1'b0, ea, eb, est);
    issue(1'b1, 1'b1, 8'h08, 8'h5A, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    n_checks++; if (ga !== ea || ga.ce !== 1'b1 || ga.rw !== 1'b0 || nsa !== LAT) begin n_fail++;
      $display("FAIL conflict_wb got=%h stall=%0d required=%h %0d", ga, nsa, ea, LAT); end
    @(negedge clk);
    n_checks++; if (conflict_err_a !== 1'b0 || wb_valid_a !== 1'b0) begin n_fail++;
      $display("FAIL conflict_pulse ce=%b v=%b required 0 0", conflict_err_a, wb_valid_a); end
    model(1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, ea, eb, est);
    issue(1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0, ga, gb, nsa, nsb, early);
    n_checks++; if (ga !== ea || ga.d !== 8'h5A || gb !== eb) begin n_fail++;
      $display("FAIL conflict_load got=%h/%h required=%h/%h", ga, gb, ea, eb); end
`ifdef MEM_STATS_EN
    n_checks++; if (store_count_a !== 16'd1 || load_count_a !== 16'd1) begin n_fail++;
      $display("FAIL conflict_stats st=%0d ld=%0d required 1 1", store_count_a, load_count_a); end
`endif
  endtask

  task automatic test_random();
    wb_t ga, gb, ea, eb;
    int nsa, nsb, early, est;
    logic [1:0] f;
    logic [7:0] alu, rb, ra, lv;
    logic lf;
    for (int n = 0; n < 300; n++) begin
      f = 2'($urandom_range(0, 3));
      alu = 8'($urandom); rb = 8'($urandom); ra = 8'($urandom); lv = 8'($urandom);
      lf = 1'($urandom);
      if (n % 3 == 0) alu = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
      model(f[0], f[1], alu, rb, ra, lv, lf, ea, eb, est);
      issue(f[0], f[1], alu, rb, ra, lv, lf, ga, gb, nsa, nsb, early);
      n_checks++; if (nsa !== est || nsb !== est || early !== 0) begin n_fail++;
        $display("FAIL rand_stall n=%0d stall=%0d/%0d early_wb=%0d required %0d 0",
                 n, nsa, nsb, early, est); end
      n_checks++; if (ga !== ea) begin n_fail++;
        $display("FAIL rand_wb_a n=%0d got=%h required=%h", n, ga, ea); end
      n_checks++; if (gb !== eb) begin n_fail++;
        $display("FAIL rand_wb_b n=%0d got=%h required=%h", n, gb, eb); end
    end
`ifdef MEM_STATS_EN
    n_checks++; if (load_count_a !== 16'(ld_cnt) || store_count_a !== 16'(st_cnt)) begin
      n_fail++;
      $display("FAIL rand_stats ld=%0d st=%0d required %0d %0d",
               load_count_a, store_count_a, ld_cnt, st_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_conflict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
